// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble payload, IF/ID field offsets
// and the stage-register occupancy encoding.
package pipe_pkg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int INSTR_LSB = 32;
    localparam int PC_LSB    = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_e;

    // The encoding doubles as the entry count.
    function automatic logic [1:0] st_occ(input stage_st_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload holding register with load and clear-to-bubble.
// Clear has priority over load.
module pipe_skid_entry #(
    parameter int          W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with stall, flush-to-bubble,
// optional skid entry and a saturating flush-kill counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               DATA_W     = 64,
    parameter int               SKID       = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP),
    parameter int               CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  kill_cnt
);

    stage_st_e state_q;
    stage_st_e state_d;

    logic              out_valid_q;
    logic              accept;
    logic              pop;
    logic              main_ld;
    logic              main_clr;
    logic              skid_ld;
    logic              skid_clr;
    logic              from_skid;
    logic              flush_kill;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  kill_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid_q && out_ready && !stall;
    assign main_d = from_skid ? skid_q : in_data;

    always_comb begin
        state_d   = state_q;
        main_ld   = 1'b0;
        main_clr  = 1'b0;
        skid_ld   = 1'b0;
        skid_clr  = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_MAIN;
                        main_ld = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        // Only reachable with a skid entry.
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d   = ST_MAIN;
                        main_ld   = 1'b1;
                        from_skid = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign out_valid = out_valid_q;
    assign occ       = st_occ(state_q);

    pipe_skid_entry #(
        .W       (DATA_W),
        .RST_VAL (BUBBLE_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .q     (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = in_ready_q;

            pipe_skid_entry #(
                .W       (DATA_W),
                .RST_VAL (BUBBLE_VAL)
            ) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_ld),
                .clear (skid_clr),
                .d     (in_data),
                .q     (skid_q)
            );
        end else begin : g_noskid
            logic unused_skid;

            assign in_ready    = !out_valid_q || (out_ready && !stall);
            assign skid_q      = BUBBLE_VAL;
            assign unused_skid = skid_ld | skid_clr;
        end
    endgenerate

    // A flush counts only when it actually destroys a beat.
    assign flush_kill = flush && ((state_q != ST_EMPTY) || accept);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kill_q <= '0;
        end else if (flush_kill && (kill_q != '1)) begin
            kill_q <= kill_q + CNT_W'(1);
        end
    end

    assign kill_cnt = kill_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in lockstep and
// compared every cycle against a FIFO-level reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        stall;
    logic        flush;
    logic [63:0] in_data;

    always #5 clk = ~clk;

    logic        d_ir [3];
    logic        d_ov [3];
    logic [63:0] d_od [3];
    logic [1:0]  d_oc [3];
    logic [15:0] d_kc [3];
    logic [15:0] kc0;
    logic [15:0] kc1;
    logic [1:0]  kc2;

    assign d_kc[0] = kc0;
    assign d_kc[1] = kc1;
    assign d_kc[2] = {14'b0, kc2};

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d_ir[0]), .in_data(in_data),
        .out_valid(d_ov[0]), .out_ready(out_ready), .out_data(d_od[0]),
        .stall(stall), .flush(flush), .occ(d_oc[0]), .kill_cnt(kc0)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d_ir[1]), .in_data(in_data),
        .out_valid(d_ov[1]), .out_ready(out_ready), .out_data(d_od[1]),
        .stall(stall), .flush(flush), .occ(d_oc[1]), .kill_cnt(kc1)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(1),
                     .BUBBLE_VAL(64'hBBBB), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d_ir[2]), .in_data(in_data),
        .out_valid(d_ov[2]), .out_ready(out_ready), .out_data(d_od[2]),
        .stall(stall), .flush(flush), .occ(d_oc[2]), .kill_cnt(kc2)
    );

    // Reference model: a bounded FIFO per instance.
    logic [63:0] m_buf  [3][2];
    int          m_cnt  [3];
    logic [63:0] m_od   [3];
    int          m_kill [3];
    logic        m_ir   [3];
    int          m_cap  [3] = '{2, 1, 2};
    int          m_kmax [3] = '{65535, 65535, 3};
    logic [63:0] m_bub  [3] = '{64'h0, 64'h0, 64'hBBBB};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] d,
                       input logic ordy, input logic st,
                       input logic fl, input logic rn);
        logic acc [3];
        logic pp  [3];
        logic ir;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst_n     = rn;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (m_cap[i] == 1) ir = (m_cnt[i] == 0) || (ordy && !st);
            else               ir = m_ir[i];
            if (rn) chk($sformatf("in_ready[%0d]", i), 64'(d_ir[i]), 64'(ir));
            acc[i] = v && ir;
            pp[i]  = (m_cnt[i] > 0) && ordy && !st;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!rn) begin
                m_cnt[i]  = 0;
                m_od[i]   = m_bub[i];
                m_kill[i] = 0;
            end else if (fl) begin
                if ((m_cnt[i] > 0 || acc[i]) && m_kill[i] < m_kmax[i])
                    m_kill[i]++;
                m_cnt[i] = 0;
                m_od[i]  = m_bub[i];
            end else begin
                if (pp[i]) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_cnt[i]--;
                end
                if (acc[i]) begin
                    m_buf[i][m_cnt[i]] = d;
                    m_cnt[i]++;
                end
                if (m_cnt[i] > 0) m_od[i] = m_buf[i][0];
            end
            m_ir[i] = (m_cnt[i] < 2);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out_valid[%0d]", i), 64'(d_ov[i]), 64'(m_cnt[i] > 0));
            chk($sformatf("out_data[%0d]", i), d_od[i], m_od[i]);
            chk($sformatf("occ[%0d]", i), 64'(d_oc[i]), 64'(m_cnt[i]));
            chk($sformatf("kill_cnt[%0d]", i), 64'(d_kc[i]), 64'(m_kill[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_od[i]   = m_bub[i];
            m_kill[i] = 0;
            m_ir[i]   = 1'b1;
        end

        // Reset with a beat offered.
        cyc(1, 64'hDEAD, 1, 0, 0, 0);
        cyc(1, 64'hDEAD, 1, 0, 0, 0);
        chk("rst_out_data", d_od[0], 64'h0);
        cyc(0, 64'h0, 1, 0, 0, 1);

        // Streaming.
        for (int k = 1; k <= 8; k++) cyc(1, 64'(k), 1, 0, 0, 1);
        cyc(0, 64'h0, 1, 0, 0, 1);

        // Backpressure, then drain.
        cyc(1, 64'h10, 0, 0, 0, 1);
        cyc(1, 64'h11, 0, 0, 0, 1);
        chk("bp_occ2", 64'(d_oc[0]), 64'd2);
        cyc(1, 64'h12, 0, 0, 0, 1);
        cyc(1, 64'h12, 0, 0, 0, 1);
        cyc(1, 64'h12, 1, 0, 0, 1);
        cyc(1, 64'h12, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 64'h0, 1, 0, 0, 1);

        // Load-use stall.
        cyc(1, 64'h20, 1, 0, 0, 1);
        cyc(0, 64'h0, 1, 1, 0, 1);
        chk("stall_hold", d_od[0], 64'h20);
        cyc(0, 64'h0, 1, 0, 0, 1);
        cyc(0, 64'h0, 1, 0, 0, 1);

        // Flush with contents, then flush while empty.
        cyc(1, 64'h30, 0, 0, 0, 1);
        cyc(1, 64'h31, 0, 0, 0, 1);
        cyc(1, 64'h32, 0, 0, 1, 1);
        chk("flush_kill", 64'(d_kc[0]), 64'd1);
        cyc(0, 64'h0, 1, 0, 1, 1);
        chk("flush_empty", 64'(d_kc[0]), 64'd1);

        // Saturation on the narrow counter.
        for (int k = 0; k < 5; k++) begin
            cyc(1, 64'h40 + 64'(k), 0, 0, 0, 1);
            cyc(0, 64'h0, 0, 0, 1, 1);
        end
        chk("kill_sat", 64'(d_kc[2]), 64'd3);

        // Flush beats stall; reset beats flush.
        cyc(1, 64'h50, 1, 0, 0, 1);
        cyc(1, 64'h51, 0, 1, 1, 1);
        cyc(1, 64'h60, 1, 0, 0, 1);
        cyc(1, 64'h61, 1, 0, 1, 0);
        chk("rst_over_flush", 64'(d_kc[0]), 64'd0);
        cyc(0, 64'h0, 1, 0, 0, 1);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 3) != 0),
                {$urandom, $urandom},
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 49) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
